// File: rtl/axis_spi_slave_fifo.sv
// SPI slave bridged to AXI-Stream through TX and RX FIFOs, all logic in the axis_aclk domain.
// Define AXIS_SPI_OVERRUN_CNT_EN to add the saturating o_rx_overrun_cnt output.
module axis_spi_slave_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  input  logic              i_spi_cs,
  output logic              o_spi_miso,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
`ifdef AXIS_SPI_OVERRUN_CNT_EN
  output logic [15:0]       o_rx_overrun_cnt,
`endif
  output logic              m_axis_tkeep
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT    = CW'(DATA_W - 1);
  localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic          IDLE_CLK    = (CPOL != 0);
  localparam logic          SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));

  // ---------------------------------------------------------------- synchronisers
  logic [1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic       r_sclk_d, r_cs_d, r_armed, r_ready_en;

  // CS sync resets to "selected" so a CS already low at reset release never looks like a fresh fall.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_sclk_sync <= {IDLE_CLK, IDLE_CLK};
      r_sclk_d    <= IDLE_CLK;
      r_mosi_sync <= '0;
      r_cs_sync   <= '0;
      r_cs_d      <= 1'b0;
      r_armed     <= 1'b0;
      r_ready_en  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_sclk_sync <= {r_sclk_sync[0], i_spi_clk};
      r_sclk_d    <= r_sclk_sync[1];
      r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
      r_cs_sync   <= {r_cs_sync[0], i_spi_cs};
      r_cs_d      <= r_cs_sync[1];
      r_ready_en  <= 1'b1;
      if (r_cs_sync[1]) r_armed <= 1'b1;
    end
  end

  logic w_sclk, w_mosi, w_cs_n, w_framing, w_cs_fall, w_cs_edge;
  logic w_sample, w_shift, w_word_done;
  logic [CW-1:0] r_bit_cnt;

  assign w_sclk      = r_sclk_sync[1];
  assign w_mosi      = r_mosi_sync[1];
  assign w_cs_n      = r_cs_sync[1];
  assign w_framing   = r_armed & ~w_cs_n;
  assign w_cs_fall   = r_armed & r_cs_d & ~w_cs_n;
  assign w_cs_edge   = r_cs_d ^ w_cs_n;
  assign w_sample    = w_framing & (SAMPLE_RISE ? (~r_sclk_d & w_sclk) : (r_sclk_d & ~w_sclk));
  assign w_shift     = w_framing & (SAMPLE_RISE ? (r_sclk_d & ~w_sclk) : (~r_sclk_d & w_sclk));
  assign w_word_done = w_sample & (r_bit_cnt == LAST_BIT);

  // ---------------------------------------------------------------- shift datapath
  logic [DATA_W-1:0] r_rx_shift, r_tx_shift, r_rx_word;
  logic [DATA_W-1:0] w_rx_next, w_tx_shifted;
  logic              r_rx_push, r_rx_user, r_first, w_tx_bit;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_rx_next    = r_rx_shift;
    w_tx_shifted = r_tx_shift;
    w_tx_bit     = r_tx_shift[0];
    if (MSB_FIRST != 0) begin
      w_rx_next    = {r_rx_shift[DATA_W-2:0], w_mosi};
      w_tx_shifted = {r_tx_shift[DATA_W-2:0], 1'b1};
      w_tx_bit     = r_tx_shift[DATA_W-1];
    end else begin
      w_rx_next    = {w_mosi, r_rx_shift[DATA_W-1:1]};
      w_tx_shifted = {1'b1, r_tx_shift[DATA_W-1:1]};
    end
  end

  logic              w_tx_load, w_tx_pop, w_tx_push;
  logic [DATA_W-1:0] w_tx_head;
  logic [AW:0]       r_tx_count;

  assign w_tx_load = w_cs_fall | w_word_done;
  assign w_tx_pop  = w_tx_load & (r_tx_count != '0);

  // A shift edge seen with the counter at 0 is the first edge of a word: the freshly loaded MSB stays put.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_rx_word  <= '0;
      r_rx_push  <= 1'b0;
      r_rx_user  <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_rx_push <= w_word_done;
      if (w_word_done) begin
        r_rx_word <= w_rx_next;
        r_rx_user <= r_first;
      end
      if (w_cs_edge)     r_bit_cnt <= '0;
      else if (w_sample) r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CW'(1);
      if (w_sample) r_rx_shift <= w_rx_next;
      if (w_cs_fall)        r_first <= 1'b1;
      else if (w_word_done) r_first <= 1'b0;
      if (w_tx_load)                          r_tx_shift <= w_tx_pop ? w_tx_head : '1;
      else if (w_shift && r_bit_cnt != '0)    r_tx_shift <= w_tx_shifted;
    end
  end

  assign o_spi_miso = w_framing ? w_tx_bit : 1'b1;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_tx_wr, r_tx_rd;

  assign s_axis_tready = r_ready_en & (r_tx_count != FULL_COUNT);
  assign w_tx_push     = s_axis_tvalid & s_axis_tready;
  assign w_tx_head     = r_tx_mem[r_tx_rd];

  // NOTE: FIFO storage has no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge axis_aclk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= s_axis_tdata;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
      r_tx_count <= r_tx_count + (AW + 1)'(w_tx_push) - (AW + 1)'(w_tx_pop);
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_W:0] r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_rx_wr, r_rx_rd;
  logic [AW:0]     r_rx_count;
  logic            w_rx_pop, w_rx_accept;

  assign m_axis_tvalid = (r_rx_count != '0);
  assign w_rx_pop      = m_axis_tvalid & m_axis_tready;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign w_rx_accept   = r_rx_push & ((r_rx_count != FULL_COUNT) | w_rx_pop);
  assign m_axis_tdata  = r_rx_mem[r_rx_rd][DATA_W-1:0];
  assign m_axis_tuser  = m_axis_tvalid & r_rx_mem[r_rx_rd][DATA_W];
  assign m_axis_tlast  = 1'b1;
  assign m_axis_tkeep  = 1'b1;

  always_ff @(posedge axis_aclk) begin
    if (w_rx_accept) r_rx_mem[r_rx_wr] <= {r_rx_user, r_rx_word};
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_accept) r_rx_wr <= r_rx_wr + AW'(1);
      if (w_rx_pop)    r_rx_rd <= r_rx_rd + AW'(1);
      r_rx_count <= r_rx_count + (AW + 1)'(w_rx_accept) - (AW + 1)'(w_rx_pop);
    end
  end

`ifdef AXIS_SPI_OVERRUN_CNT_EN
  logic        w_rx_drop;
  logic [15:0] r_overrun_cnt;

  assign w_rx_drop        = r_rx_push & ~w_rx_accept;
  assign o_rx_overrun_cnt = r_overrun_cnt;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn)                              r_overrun_cnt <= '0;
    else if (w_rx_drop && r_overrun_cnt != 16'hFFFF) r_overrun_cnt <= r_overrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_axis_spi_slave_fifo.sv
// Scoreboard bench: instance 0 is DATA_W=8 mode 0 MSB-first with FIFO_DEPTH=4,
// instances 1..3 are DATA_W=16 LSB-first in SPI modes 1..3.
module tb_axis_spi_slave_fifo;

  localparam int H = 8;  // SCLK half period in axis_aclk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sclk [4], mosi [4], cs [4], miso [4];
  logic [15:0] tx_data [4];
  logic        tx_valid [4], tx_ready [4];
  logic [15:0] rx_data [4];
  logic        rx_valid [4], rx_ready [4], rx_user [4], rx_last [4], rx_keep [4];
`ifdef AXIS_SPI_OVERRUN_CNT_EN
  logic [15:0] ovr [4];
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] exp_q [4][$];
  logic [15:0] w [8];
  logic [15:0] m [8];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DW = (g == 0) ? 8 : 16;
    logic [DW-1:0] w_rx_data;

    axis_spi_slave_fifo #(
      .DATA_W    (DW),
      .FIFO_DEPTH((g == 0) ? 4 : 16),
      .CPOL      (g / 2),
      .CPHA      (g % 2),
      .MSB_FIRST ((g == 0) ? 1 : 0)
    ) u_dut (
      .axis_aclk       (clk),
      .axis_aresetn    (rst_n),
      .i_spi_clk       (sclk[g]),
      .i_spi_mosi      (mosi[g]),
      .i_spi_cs        (cs[g]),
      .o_spi_miso      (miso[g]),
      .s_axis_tdata    (tx_data[g][DW-1:0]),
      .s_axis_tvalid   (tx_valid[g]),
      .s_axis_tready   (tx_ready[g]),
      .m_axis_tdata    (w_rx_data),
      .m_axis_tvalid   (rx_valid[g]),
      .m_axis_tready   (rx_ready[g]),
      .m_axis_tuser    (rx_user[g]),
      .m_axis_tlast    (rx_last[g]),
`ifdef AXIS_SPI_OVERRUN_CNT_EN
      .o_rx_overrun_cnt(ovr[g]),
`endif
      .m_axis_tkeep    (rx_keep[g])
    );

    assign rx_data[g] = 16'(w_rx_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every RX handshake against the scoreboard, and the held head while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 4; g++) begin
        if (rx_valid[g] && rx_ready[g]) begin
          if (exp_q[g].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_unexpected_g%0d: got data 0x%0h user %0b with nothing expected", g, rx_data[g], rx_user[g]);
          end else begin
            logic [16:0] e;
            e = exp_q[g].pop_front();
            check($sformatf("rx_data_g%0d", g), rx_data[g], e[15:0]);
            check($sformatf("rx_user_g%0d", g), rx_user[g], e[16]);
            check($sformatf("rx_last_keep_g%0d", g), {rx_last[g], rx_keep[g]}, 2'b11);
          end
        end
      end
      if (rx_valid[0] && !rx_ready[0] && exp_q[0].size() != 0) begin
        check("rx_stall_data", rx_data[0], exp_q[0][0][15:0]);
        check("rx_stall_user", rx_user[0], exp_q[0][0][16]);
      end
    end
  end

  task automatic tx_push(input int g, input logic [15:0] d);
    bit done = 0;
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = tx_ready[g];
      wait_clk(1);
    end
    tx_valid[g] = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL tx_push_timeout_g%0d: tready stayed 0 for 50 cycles", g);
    end
  endtask

  // One CS frame of n words; the first n_keep are expected on RX, miso_w is the expected MISO stream.
  task automatic spi_frame(input int g, input logic [15:0] mosi_w [8], input logic [15:0] miso_w [8],
                           input int n, input int n_keep);
    int   wd   = (g == 0) ? 8 : 16;
    logic pol  = (g >= 2);
    logic pha  = (g % 2) != 0;
    bit   msbf = (g == 0);
    for (int k = 0; k < n_keep; k++) exp_q[g].push_back({logic'(k == 0), mosi_w[k]});
    cs[g] = 1'b0;
    wait_clk(8);
    for (int k = 0; k < n; k++) begin
      logic [15:0] got = '0;
      for (int i = 0; i < wd; i++) begin
        int bi = msbf ? wd - 1 - i : i;
        if (!pha) begin
          mosi[g] = mosi_w[k][bi];
          wait_clk(H);
          got[bi] = miso[g];
          sclk[g] = ~pol;
          wait_clk(H);
          sclk[g] = pol;
        end else begin
          sclk[g] = ~pol;
          mosi[g] = mosi_w[k][bi];
          wait_clk(H);
          got[bi] = miso[g];
          sclk[g] = pol;
          wait_clk(H);
        end
      end
      check($sformatf("miso_g%0d_w%0d", g, k), got, miso_w[k]);
    end
    wait_clk(H);
    cs[g] = 1'b1;
    wait_clk(16);
  endtask

  // Raw mode-0 bits on instance 0, MSB of the nbits-wide value first.
  task automatic spi_bits0(input logic [7:0] v, input int nbits, input bit chk_high);
    for (int i = 0; i < nbits; i++) begin
      mosi[0] = v[nbits-1-i];
      wait_clk(H);
      if (chk_high) check("miso_ignored_frame", miso[0], 1'b1);
      sclk[0] = 1'b1;
      wait_clk(H);
      sclk[0] = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s_tvalid_g%0d", tag, g), rx_valid[g], 1'b0);
      check($sformatf("%s_tready_g%0d", tag, g), tx_ready[g], 1'b0);
      check($sformatf("%s_miso_g%0d", tag, g), miso[g], 1'b1);
      check($sformatf("%s_tuser_g%0d", tag, g), rx_user[g], 1'b0);
    end
  endtask

  initial begin
    for (int g = 0; g < 4; g++) begin
      sclk[g]     = (g >= 2);
      mosi[g]     = 1'b0;
      cs[g]       = 1'b1;
      tx_data[g]  = '0;
      tx_valid[g] = 1'b0;
      rx_ready[g] = 1'b1;
    end
    w = '{default: '0};
    m = '{default: '0};

    wait_clk(4);
    check_reset_outputs("reset");
`ifdef AXIS_SPI_OVERRUN_CNT_EN
    check("overrun_reset", ovr[0], 16'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    for (int g = 0; g < 4; g++) check($sformatf("tready_after_reset_g%0d", g), tx_ready[g], 1'b1);
    wait_clk(8);

    // Two-word frame with TX preloaded
    tx_push(0, 16'h11);
    tx_push(0, 16'h22);
    w[0] = 16'hA5; w[1] = 16'h3C; m[0] = 16'h11; m[1] = 16'h22;
    spi_frame(0, w, m, 2, 2);

    // Empty TX FIFO underruns to all-ones
    w[0] = 16'h96; w[1] = 16'h0F; m[0] = 16'hFF; m[1] = 16'hFF;
    spi_frame(0, w, m, 2, 2);

    // RX overrun: depth 4, six words, consumer stalled
    rx_ready[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w[k] = 16'(k + 1);
      m[k] = 16'hFF;
    end
    spi_frame(0, w, m, 6, 4);
    wait_clk(4);
    check("rx_valid_while_stalled", rx_valid[0], 1'b1);
`ifdef AXIS_SPI_OVERRUN_CNT_EN
    check("overrun_cnt", ovr[0], 16'd2);
`endif
    rx_ready[0] = 1'b1;
    for (int i = 0; i < 60 && exp_q[0].size() != 0; i++) wait_clk(1);
    check("overrun_drain_left", exp_q[0].size(), 0);
    wait_clk(4);
    check("rx_empty_after_drain", rx_valid[0], 1'b0);

    // Partial word at CS rise is discarded; next frame starts aligned
    cs[0] = 1'b0;
    wait_clk(8);
    spi_bits0(8'h15, 5, 1'b0);
    wait_clk(H);
    cs[0] = 1'b1;
    wait_clk(16);
    check("partial_no_push", rx_valid[0], 1'b0);
    w[0] = 16'hC3; m[0] = 16'hFF;
    spi_frame(0, w, m, 1, 1);

    // Reset pulse mid-word with CS low; TX word 0x77 must be flushed by the reset
    tx_push(0, 16'h77);
    cs[0] = 1'b0;
    wait_clk(8);
    spi_bits0(8'h05, 3, 1'b0);
    rst_n = 1'b0;
    wait_clk(2);
    check_reset_outputs("midreset");
    @(negedge clk) rst_n = 1'b1;
    wait_clk(2);
    spi_bits0(8'h16, 5, 1'b1);
    wait_clk(H);
    cs[0] = 1'b1;
    wait_clk(16);
    check("ignored_frame_no_push", rx_valid[0], 1'b0);
    w[0] = 16'h5A; m[0] = 16'hFF;
    spi_frame(0, w, m, 1, 1);

    // Modes 1..3, 16-bit, LSB first
    for (int g = 1; g < 4; g++) begin
      tx_push(g, 16'hBEEF);
      w[0] = 16'h1234; m[0] = 16'hBEEF;
      spi_frame(g, w, m, 1, 1);
    end

    wait_clk(20);
    for (int g = 0; g < 4; g++) check($sformatf("scoreboard_left_g%0d", g), exp_q[g].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
